// File: rtl/reqresp_wb_bridge.sv
// Bridge from a core req/resp memory port to a classic Wishbone master, one transfer at a time.
// Handles byte-lane strobes, write-data replication, misalignment, bus timeout and response buffering.
module reqresp_wb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int RESP_DEPTH     = 2,
  parameter int REG_RESP       = 1,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int ALIGN_RDATA    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  output logic                  req_ready,
  input  logic                  cmd,
  input  logic [1:0]            width,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  err,
  output logic                  resp,
  input  logic                  resp_ready,
  output logic                  bus_cyc,
  output logic                  bus_stb,
  output logic                  bus_we,
  output logic [3:0]            bus_wstrb,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_data_out,
  input  logic [31:0]           bus_data_in,
  input  logic                  bus_ack,
  input  logic                  bus_err
);

  localparam int PTR_W  = $clog2(RESP_DEPTH);
  localparam int OCC_W  = $clog2(RESP_DEPTH + 2);
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_ERRQ} state_t;

  state_t             state_q, state_d;
  logic               live_q;
  logic [1:0]         byte_off_q;
  logic [TMO_W-1:0]   tmo_cnt_q;
  logic               timeout_hit;

  logic               misaligned;
  logic [3:0]         req_strb;
  logic [31:0]        req_data;
  logic               accept;

  logic               push, push_err, pop;
  logic [31:0]        push_data, rdata_aligned;
  logic [32:0]        fifo_mem [RESP_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]   fifo_count_q;
  logic               fifo_empty;
  logic [32:0]        fifo_head;
  logic               out_valid;

  // NOTE: every combinational output gets a default before the case, so no latch can be inferred.
  always_comb begin
    misaligned = 1'b0;
    req_strb   = 4'b0000;
    req_data   = wdata;
    case (width)
      2'b00: begin
        req_strb = 4'b0001 << addr[1:0];
        req_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        misaligned = addr[0];
        req_strb   = 4'b0011 << {addr[1], 1'b0};
        req_data   = {2{wdata[15:0]}};
      end
      2'b10: begin
        misaligned = (addr[1:0] != 2'b00);
        req_strb   = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign fifo_empty    = (fifo_count_q == '0);
  assign fifo_head     = fifo_mem[rd_ptr_q];
  assign rdata_aligned = (ALIGN_RDATA != 0) ? (bus_data_in >> {byte_off_q, 3'b000}) : bus_data_in;
  assign timeout_hit   = TMO_EN && (tmo_cnt_q == TMO_LAST);

  // Space is reserved at accept time, so a completing transfer always has a FIFO slot.
  assign req_ready = live_q && (state_q == S_IDLE) &&
                     ((fifo_count_q + OCC_W'(out_valid)) < OCC_W'(RESP_DEPTH + REG_RESP));

  assign bus_cyc = (state_q == S_BUS);
  assign bus_stb = bus_cyc;

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    push      = 1'b0;
    push_err  = 1'b0;
    push_data = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req && req_ready) begin
          accept  = 1'b1;
          state_d = misaligned ? S_ERRQ : S_BUS;
        end
      end
      S_BUS: begin
        if (bus_err) begin
          push     = 1'b1;
          push_err = 1'b1;
          state_d  = S_IDLE;
        end else if (bus_ack) begin
          push      = 1'b1;
          push_data = bus_we ? 32'h0 : rdata_aligned;
          state_d   = S_IDLE;
        end else if (timeout_hit) begin
          push     = 1'b1;
          push_err = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_ERRQ: begin
        push     = 1'b1;
        push_err = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      live_q       <= 1'b0;
      bus_we       <= 1'b0;
      bus_wstrb    <= 4'b0000;
      bus_addr     <= '0;
      bus_data_out <= '0;
      byte_off_q   <= 2'b00;
      tmo_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (accept) begin
        bus_we       <= cmd;
        bus_wstrb    <= req_strb;
        bus_addr     <= {addr[ADDR_WIDTH-1:2], 2'b00};
        bus_data_out <= req_data;
        byte_off_q   <= addr[1:0];
      end
      if (TMO_EN && state_q == S_BUS) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      else                            tmo_cnt_q <= '0;
    end
  end

  // NOTE: the storage array is deliberately not reset; empty entries are never presented.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {push_err, push_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + 1'b1;
        2'b01:   fifo_count_q <= fifo_count_q - 1'b1;
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  generate
    if (REG_RESP != 0) begin : g_reg_resp
      logic        out_valid_q;
      logic [32:0] out_q;

      // Refill the output register whenever it is empty or being consumed this cycle.
      assign pop       = !fifo_empty && (!out_valid_q || resp_ready);
      assign out_valid = out_valid_q;
      assign resp      = out_valid_q;
      assign err       = out_q[32];
      assign rdata     = out_q[31:0];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          out_q       <= '0;
        end else if (pop) begin
          out_valid_q <= 1'b1;
          out_q       <= fifo_head;
        end else if (resp_ready) begin
          out_valid_q <= 1'b0;
        end
      end
    end else begin : g_fifo_resp
      assign pop       = !fifo_empty && resp_ready;
      assign out_valid = 1'b0;
      assign resp      = !fifo_empty;
      assign err       = fifo_empty ? 1'b0 : fifo_head[32];
      assign rdata     = fifo_empty ? 32'h0 : fifo_head[31:0];
    end
  endgenerate

endmodule

// File: tb/tb_reqresp_wb_bridge.sv
// Self-checking bench for reqresp_wb_bridge: directed corner cases plus randomized traffic,
// checked against a request-level model of expected bus cycles and responses.
module tb_reqresp_wb_bridge;

  localparam int AW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req, req_ready, cmd;
  logic [1:0]    width;
  logic [AW-1:0] addr;
  logic [31:0]   wdata, rdata;
  logic          err, resp, resp_ready;
  logic          bus_cyc, bus_stb, bus_we;
  logic [3:0]    bus_wstrb;
  logic [AW-1:0] bus_addr;
  logic [31:0]   bus_data_out, bus_data_in;
  logic          bus_ack, bus_err;

  reqresp_wb_bridge #(
    .ADDR_WIDTH(AW), .RESP_DEPTH(2), .REG_RESP(1), .TIMEOUT_CYCLES(TMO), .ALIGN_RDATA(1)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_ready(req_ready), .cmd(cmd), .width(width),
    .addr(addr), .wdata(wdata), .rdata(rdata), .err(err), .resp(resp), .resp_ready(resp_ready),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
    .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    int          lat;
    bit          timeout;
    bit          berr;
    bit          both;
    logic [31:0] data;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } plan_t;

  resp_t exp_q[$];
  plan_t plan_q[$];
  int    n_cmp   = 0;
  int    n_mis   = 0;
  int    rr_mode = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Present one request and record what the bus and the core should see for it.
  task automatic issue_req(input logic c, input logic [1:0] w, input logic [31:0] a,
                           input logic [31:0] d, input int lat, input bit tmo,
                           input bit berr, input bit both, input logic [31:0] bdata);
    int    budget;
    int    off;
    bit    mis;
    plan_t p;
    resp_t r;
    budget = 0;
    @(negedge clk);
    while (!req_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      check("req_ready_wait", 32'(req_ready), 32'd1);
      return;
    end
    req = 1'b1; cmd = c; width = w; addr = a; wdata = d;
    off = int'(a % 4);
    mis = (w == 2'b11) || (w == 2'b01 && off % 2 != 0) || (w == 2'b10 && off != 0);
    if (mis) begin
      r.err = 1'b1; r.rdata = 32'h0;
    end else begin
      p.lat = lat; p.timeout = tmo; p.berr = berr; p.both = both; p.data = bdata; p.we = c;
      p.wstrb = (w == 2'b00) ? 4'(1 << off) : (w == 2'b01) ? 4'(3 << (off & 2)) : 4'hF;
      p.wdata = (w == 2'b00) ? d[7:0] * 32'h01010101 :
                (w == 2'b01) ? d[15:0] * 32'h00010001 : d;
      p.addr  = a - 32'(off);
      plan_q.push_back(p);
      if (tmo || berr) begin
        r.err = 1'b1; r.rdata = 32'h0;
      end else begin
        r.err = 1'b0; r.rdata = c ? 32'h0 : (bdata >> (8 * off));
      end
    end
    exp_q.push_back(r);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || plan_q.size() != 0 || bus_cyc) && b < 500) begin
      @(negedge clk);
      b++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Wishbone slave: follows the plan recorded for each bus cycle, then sends a stray ack after timeouts.
  initial begin : slave
    plan_t cur;
    bit    active;
    bit    late;
    int    n;
    active = 1'b0; late = 1'b0; n = 0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_data_in = 32'h0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0; bus_err = 1'b0; bus_data_in = $urandom;
      if (rst) begin
        active = 1'b0; late = 1'b0;
      end else begin
        if (active && !bus_cyc) begin
          check("cyc_len", 32'(n), cur.timeout ? 32'(TMO) : 32'(cur.lat + 1));
          if (cur.timeout) late = 1'b1;
          active = 1'b0;
        end
        if (bus_cyc) begin
          if (!active) begin
            if (plan_q.size() == 0) begin
              check("unplanned_cyc", 32'd1, 32'd0);
              cur.lat = 0; cur.timeout = 1'b1; cur.berr = 1'b0; cur.both = 1'b0; cur.data = 32'h0;
              cur.we = 1'b0; cur.wstrb = 4'h0; cur.addr = 32'h0; cur.wdata = 32'h0;
            end else begin
              cur = plan_q.pop_front();
            end
            active = 1'b1; n = 0;
          end
          check("bus_stb", 32'(bus_stb), 32'd1);
          check("bus_we", 32'(bus_we), 32'(cur.we));
          check("bus_wstrb", 32'(bus_wstrb), 32'(cur.wstrb));
          check("bus_addr", bus_addr, cur.addr);
          if (cur.we) check("bus_data_out", bus_data_out, cur.wdata);
          if (!cur.timeout && n == cur.lat) begin
            bus_ack = !cur.berr || cur.both;
            bus_err = cur.berr;
            bus_data_in = cur.data;
          end
          n++;
        end else if (late) begin
          bus_ack = 1'b1; bus_data_in = 32'hBAD0BAD0; late = 1'b0;
        end
      end
    end
  end

  // Core side: consumes responses under the selected backpressure mode, in request order.
  initial begin : consumer
    resp_t       e;
    bit          hold;
    logic [31:0] h_rdata;
    logic        h_err;
    hold = 1'b0; h_rdata = 32'h0; h_err = 1'b0;
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0; resp_ready = 1'b0;
      end else begin
        if (hold) begin
          check("held_resp", 32'(resp), 32'd1);
          check("held_rdata", rdata, h_rdata);
          check("held_err", 32'(err), 32'(h_err));
        end
        case (rr_mode)
          0:       resp_ready = 1'b0;
          1:       resp_ready = 1'b1;
          default: resp_ready = 1'($urandom_range(0, 1));
        endcase
        if (resp) begin
          if (exp_q.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
          end else if (resp_ready) begin
            e = exp_q.pop_front();
            check("resp_rdata", rdata, e.rdata);
            check("resp_err", 32'(err), 32'(e.err));
          end
          hold = !resp_ready; h_rdata = rdata; h_err = err;
        end else begin
          hold = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int b;
    rst = 1'b1; req = 1'b0; cmd = 1'b0; width = 2'b00; addr = '0; wdata = 32'h0;
    #3;
    check("rst_bus_cyc", 32'(bus_cyc), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_resp", 32'(resp), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Word read with immediate ack: response latency through the output register.
    rr_mode = 1;
    issue_req(1'b0, 2'b10, 32'h100, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    b = 0;
    #1;
    while (!bus_ack && b < 20) begin
      @(negedge clk); #1; b++;
    end
    check("t1_ack_seen", 32'(bus_ack), 32'd1);
    check("t1_wstrb", 32'(bus_wstrb), 32'hF);
    @(negedge clk); #1;
    check("t1_resp_early", 32'(resp), 32'd0);
    check("t1_cyc_dropped", 32'(bus_cyc), 32'd0);
    @(negedge clk); #1;
    check("t1_resp", 32'(resp), 32'd1);
    check("t1_rdata", rdata, 32'hDEADBEEF);
    check("t1_err", 32'(err), 32'd0);
    drain();

    issue_req(1'b1, 2'b00, 32'h103, 32'h000000A5, 2, 1'b0, 1'b0, 1'b0, 32'h0);
    drain();
    issue_req(1'b0, 2'b01, 32'h202, 32'h0, 1, 1'b0, 1'b0, 1'b0, 32'h1234ABCD);
    drain();
    issue_req(1'b0, 2'b10, 32'h101, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    drain();
    issue_req(1'b0, 2'b10, 32'h400, 32'h0, 0, 1'b1, 1'b0, 1'b0, 32'h0);
    drain();
    issue_req(1'b0, 2'b10, 32'h404, 32'h0, 7, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D);
    drain();

    // Stalled consumer: three reads fill output register plus FIFO, then release.
    rr_mode = 0;
    issue_req(1'b0, 2'b10, 32'h500, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h11111111);
    issue_req(1'b0, 2'b10, 32'h504, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h22222222);
    issue_req(1'b0, 2'b10, 32'h508, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h33333333);
    repeat (6) @(negedge clk);
    #1;
    check("bp_req_ready", 32'(req_ready), 32'd0);
    check("bp_resp_held", 32'(resp), 32'd1);
    check("bp_head_rdata", rdata, 32'h11111111);
    rr_mode = 1;
    drain();

    rr_mode = 2;
    for (int i = 0; i < 150; i++) begin
      logic [1:0]  w;
      logic [31:0] a;
      int          sel;
      w   = 2'($urandom_range(0, 3));
      a   = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = (w == 2'b10) ? 2'b00 : (w == 2'b01) ? {a[1], 1'b0} : a[1:0];
      sel = $urandom_range(0, 15);
      issue_req(1'($urandom_range(0, 1)), w, a, $urandom, $urandom_range(0, 7),
                sel == 0, sel == 1 || sel == 2, sel == 2, $urandom);
    end
    rr_mode = 1;
    drain();

    // Asynchronous reset in the middle of a bus cycle discards the transfer.
    issue_req(1'b0, 2'b10, 32'h600, 32'h0, 0, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    check("mid_rst_cyc_before", 32'(bus_cyc), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_cyc", 32'(bus_cyc), 32'd0);
    check("mid_rst_resp", 32'(resp), 32'd0);
    exp_q.delete();
    plan_q.delete();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("post_rst_cyc", 32'(bus_cyc), 32'd0);
    check("post_rst_resp", 32'(resp), 32'd0);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
